branch_predict_unit: RTL

Parametrised successor to the single-cycle branch comparator. Combines signed/unsigned branch-condition evaluation with a table of 2-bit saturating counters that predicts direction at fetch and trains on resolution at execute. Sits between the fetch PC path and the execute stage. Drives the next-PC mux (`pred_taken`) and the flush/redirect logic (`res_mispredict`).

---
 rtl/branch_pkg.sv | 39 +++
 rtl/branch_compare.sv | 39 +++
 rtl/branch_predict_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit.
//   branch_type_e : 3-bit resolved-branch type encoding
//   BR_CTR_*      : 2-bit saturating counter states
//   ctr_update    : saturating counter training step
//   is_cond_branch: true for the conditional compare types (BEQ..BGEU)
package branch_pkg;

    typedef enum logic [2:0] {
        BrNone = 3'b000,
        BrBeq  = 3'b001,
        BrBne  = 3'b010,
        BrBlt  = 3'b011,
        BrBge  = 3'b100,
        BrBltu = 3'b101,
        BrBgeu = 3'b110,
        BrJump = 3'b111
    } branch_type_e;

    localparam logic [1:0] BR_CTR_SNT = 2'b00;
    localparam logic [1:0] BR_CTR_WNT = 2'b01;
    localparam logic [1:0] BR_CTR_WT  = 2'b10;
    localparam logic [1:0] BR_CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != BR_CTR_ST) nxt = ctr + 2'b01;
        end else begin
            if (ctr != BR_CTR_SNT) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    function automatic logic is_cond_branch(input logic [2:0] btype);
        return (btype != BrNone) && (btype != BrJump);
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch-condition evaluation.
//   branch_type  in  : 3-bit branch_type_e encoding
//   rdata1/2     in  : compare operands (XLEN)
//   taken        out : condition outcome (jump always 1, none always 0)
module branch_compare
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rdata1 == rdata2);
    assign lt_s = ($signed(rdata1) < $signed(rdata2));
    assign lt_u = (rdata1 < rdata2);

    always_comb begin
        taken = 1'b0;
        case (branch_type_e'(branch_type))
            BrNone: taken = 1'b0;
            BrBeq:  taken = eq;
            BrBne:  taken = ~eq;
            BrBlt:  taken = lt_s;
            BrBge:  taken = ~lt_s;
            BrBltu: taken = lt_u;
            BrBgeu: taken = ~lt_u;
            BrJump: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: 2-bit saturating-counter direction table looked up at
// fetch and trained at execute, plus branch outcome/mispredict evaluation.
// Optional statistics counters are built only when BPU_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
//   clk, rst_n                      : clock, async active-low reset
//   pred_valid, pred_pc, pred_taken : fetch-side lookup (combinational)
//   res_valid, res_pc, res_branch_type, res_rdata1, res_rdata2,
//   res_pred_taken                  : execute-side resolution inputs
//   res_taken, res_mispredict       : resolution outcome (combinational)
//   stat_branches, stat_mispredicts : resolved conditional / mispredict counts
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_valid,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [2:0]      res_branch_type,
    input  logic [XLEN-1:0] res_rdata1,
    input  logic [XLEN-1:0] res_rdata2,
    input  logic            res_pred_taken,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       ctr_q [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             cmp_taken;
    logic             train_en;

    // PC bits outside the table index carry no prediction information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    // Lookup reads the registered table directly: a same-cycle update to the
    // same index is not bypassed.
    assign pred_taken = pred_valid & ctr_q[pred_idx][1];

    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .branch_type (res_branch_type),
        .rdata1      (res_rdata1),
        .rdata2      (res_rdata2),
        .taken       (cmp_taken)
    );

    assign res_taken      = res_valid & cmp_taken;
    assign res_mispredict = res_valid & (res_taken ^ res_pred_taken);

    // Jumps and non-branches resolve but never train.
    assign train_en = res_valid & is_cond_branch(res_branch_type);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (train_en) begin
            ctr_q[res_idx] <= ctr_update(ctr_q[res_idx], cmp_taken);
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= 32'h0;
            stat_mispredicts_q <= 32'h0;
        end else begin
            if (train_en)       stat_branches_q    <= stat_branches_q + 32'd1;
            if (res_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_branches    = 32'h0;
    assign stat_mispredicts = 32'h0;
`endif

endmodule
